// File: rtl/key_event_encoder_if.sv
// key_event_encoder_if: valid/ready event channel from the key input stage to the calculator core.
interface key_event_encoder_if;
   logic       key_valid;
   logic [4:0] key_code;
   logic       key_ready;
   modport master (output key_valid, key_code, input key_ready);
   modport slave (input key_valid, key_code, output key_ready);
endinterface

// File: rtl/key_event_encoder.sv
// key_event_encoder: synchronise, debounce and encode keypad/switch presses into a queued event stream.
// Define KEY_REPEAT_EN to re-enqueue a single held key after REPEAT_DELAY, then every REPEAT_RATE cycles.
module key_event_encoder #(
   parameter int DEB_CYCLES   = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int REPEAT_DELAY = 2048,
   parameter int REPEAT_RATE  = 512
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [11:0]                      swp_i,
   input  logic [7:0]                       swd_i,
   key_event_encoder_if.master              kif,
   output logic                             key_held_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
   output logic                             ovf_o,
   output logic                             multi_o
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   logic [19:0]   s1_q, s2_q, prev_q, deb_q, deb_d, new_w;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [LW-1:0] lvl_q;
   logic [4:0]    push_code;
   logic          change, push, pop, full, do_push, ovf_d, multi_d;
   logic          key_held_q, ovf_q, multi_q;

   // Vector layout is {swp, swd}; the lowest key code wins when several bits are set.
   function automatic logic [4:0] enc(input logic [19:0] v);
      logic [23:0] byc;
      byc = '0;
      byc[23:16] = v[7:0];
      byc[11] = v[8];
      byc[10] = v[9];
      byc[0] = v[10];
      for (int k = 3; k < 12; k++) byc[12-k] = v[8+k];
      enc = 5'd0;
      for (int i = 23; i >= 0; i--) if (byc[i]) enc = 5'(i);
   endfunction

   always_comb begin
      change  = s2_q != prev_q;
      cnt_d   = change ? '0 : (cnt_q == CW'(DEB_CYCLES) ? cnt_q : cnt_q + 1'b1);
      deb_d   = (!change && cnt_q == CW'(DEB_CYCLES)) ? s2_q : deb_q;
      new_w   = deb_d & ~deb_q;
      multi_d = (new_w & (new_w - 20'd1)) != '0;
      pop     = kif.key_valid & kif.key_ready;
      full    = lvl_q == LW'(FIFO_DEPTH);
      do_push = push & (~full | pop);
      ovf_d   = push & full & ~pop;
   end

`ifdef KEY_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   logic [RW-1:0] rpt_q, rpt_d;
   logic          single, rpt;

   // Timer counts down to the next repeat; any debounced change reloads the initial delay.
   always_comb begin
      single    = deb_q != '0 && (deb_q & (deb_q - 20'd1)) == '0;
      rpt       = deb_d == deb_q && single && rpt_q == '0;
      rpt_d     = deb_d != deb_q ? RW'(REPEAT_DELAY - 1) :
                  rpt ? RW'(REPEAT_RATE - 1) :
                  rpt_q != '0 ? rpt_q - 1'b1 : rpt_q;
      push      = (|new_w) | rpt;
      push_code = |new_w ? enc(new_w) : enc(deb_q);
   end

   always_ff @(posedge clk) rpt_q <= rst ? '0 : rpt_d;
`else
   logic unused_rpt;
   assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};

   always_comb begin
      push      = |new_w;
      push_code = enc(new_w);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         prev_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= '0;
         key_held_q <= 1'b0;
         ovf_q      <= 1'b0;
         multi_q    <= 1'b0;
         mem_q      <= '{default: '0};
         wr_q       <= '0;
         rd_q       <= '0;
         lvl_q      <= '0;
      end else begin
         s1_q       <= {swp_i, swd_i};
         s2_q       <= s1_q;
         prev_q     <= s2_q;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         key_held_q <= |deb_d;
         ovf_q      <= ovf_d;
         multi_q    <= multi_d;
         if (do_push) begin
            mem_q[wr_q] <= push_code;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         lvl_q <= lvl_q + LW'(do_push) - LW'(pop);
      end
   end

   assign kif.key_valid = lvl_q != '0;
   assign kif.key_code  = mem_q[rd_q];
   assign key_held_o    = key_held_q;
   assign fifo_level_o  = lvl_q;
   assign ovf_o         = ovf_q;
   assign multi_o       = multi_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: directed checks of debounce latency, code map, FIFO full/ovf and multi-press.
module tb_key_event_encoder;
   logic        clk = 1'b0, rst = 1'b1;
   logic [11:0] swp = '0;
   logic [7:0]  swd = '0;
   logic        key_held, ovf, multi;
   logic [2:0]  fifo_level;
   logic [4:0]  last_code = '0;
   int          total = 0, bad = 0, ev_cnt = 0, ovf_cnt = 0, multi_cnt = 0;

   key_event_encoder_if kif ();

   key_event_encoder #(.DEB_CYCLES(4), .FIFO_DEPTH(4), .REPEAT_DELAY(40), .REPEAT_RATE(10)) dut (
      .clk(clk), .rst(rst), .swp_i(swp), .swd_i(swd), .kif(kif),
      .key_held_o(key_held), .fifo_level_o(fifo_level), .ovf_o(ovf), .multi_o(multi)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kif.key_valid && kif.key_ready) begin
         ev_cnt++;
         last_code = kif.key_code;
      end
      if (ovf) ovf_cnt++;
      if (multi) multi_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; swp = '0; swd = '0;
      step(3);
      total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", kif.key_valid); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%0b exp=0", key_held); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
      total++; if (multi !== 1'b0) begin bad++; $display("FAIL reset_multi got=%0b exp=0", multi); end
      total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_press;
      int b;
      b = ev_cnt;
      swp = 12'b0100_0000_0000;
      step(7);
      total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL press_early got=%0b exp=0", kif.key_valid); end
      step(1);
      total++; if (kif.key_valid !== 1'b1) begin bad++; $display("FAIL press_valid got=%0b exp=1", kif.key_valid); end
      total++; if (kif.key_code !== 5'd2) begin bad++; $display("FAIL press_code got=%0d exp=2", kif.key_code); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held got=%0b exp=1", key_held); end
      step(1);
      total++; if (kif.key_valid !== 1'b0) begin bad++; $display("FAIL press_one_cycle got=%0b exp=0", kif.key_valid); end
      step(11);
      swp = '0;
      step(20);
      total++; if (ev_cnt - b !== 1) begin bad++; $display("FAIL press_events got=%0d exp=1", ev_cnt - b); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_held got=%0b exp=0", key_held); end
   endtask

   task automatic test_bounce;
      int b;
      b = ev_cnt;
      for (int i = 0; i < 6; i++) begin
         swp[9] = ~swp[9];
         step(2);
      end
      swp[9] = 1'b1;
      step(7);
      total++; if (ev_cnt - b !== 0 || kif.key_valid !== 1'b0) begin bad++; $display("FAIL bounce_early events=%0d exp=0", ev_cnt - b); end
      step(1);
      total++; if (kif.key_valid !== 1'b1 || kif.key_code !== 5'd3) begin bad++; $display("FAIL bounce_event valid=%0b code=%0d exp valid=1 code=3", kif.key_valid, kif.key_code); end
      step(10);
      total++; if (ev_cnt - b !== 1) begin bad++; $display("FAIL bounce_events got=%0d exp=1", ev_cnt - b); end
      swp = '0;
      step(12);
   endtask

   task automatic test_function_key;
      int b;
      b = ev_cnt;
      swd = 8'b1000_0000;
      step(10);
      total++; if (last_code !== 5'd23) begin bad++; $display("FAIL fkey7_code got=%0d exp=23", last_code); end
      swd = '0;
      step(10);
      swd = 8'b0000_0001;
      step(10);
      total++; if (last_code !== 5'd16) begin bad++; $display("FAIL fkey0_code got=%0d exp=16", last_code); end
      total++; if (ev_cnt - b !== 2) begin bad++; $display("FAIL fkey_events got=%0d exp=2", ev_cnt - b); end
      swd = '0;
      step(10);
   endtask

   task automatic test_fifo_full;
      int bo;
      bo = ovf_cnt;
      kif.key_ready = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         swp[12-c] = 1'b1;
         step(10);
         swp = '0;
         step(10);
         if (c == 5) begin
            total++; if (ovf_cnt - bo !== 0) begin bad++; $display("FAIL full_no_ovf_yet got=%0d exp=0", ovf_cnt - bo); end
         end
      end
      total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
      total++; if (ovf_cnt - bo !== 1) begin bad++; $display("FAIL full_ovf got=%0d exp=1", ovf_cnt - bo); end
      step(3);
      total++; if (kif.key_code !== 5'd2) begin bad++; $display("FAIL full_stable got=%0d exp=2", kif.key_code); end
      for (int i = 0; i < 4; i++) begin
         total++; if (kif.key_valid !== 1'b1 || kif.key_code !== 5'(2 + i)) begin bad++; $display("FAIL full_drain%0d code=%0d exp=%0d", i, kif.key_code, 2 + i); end
         kif.key_ready = 1'b1;
         step(1);
         kif.key_ready = 1'b0;
      end
      total++; if (fifo_level !== 3'd0 || kif.key_valid !== 1'b0) begin bad++; $display("FAIL drained level=%0d exp=0", fifo_level); end
      kif.key_ready = 1'b1;
   endtask

   task automatic test_back_to_back;
      int bo;
      bo = ovf_cnt;
      kif.key_ready = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         swp[12-c] = 1'b1;
         step(10);
         swp = '0;
         step(10);
      end
      swp[6] = 1'b1;
      step(7);
      kif.key_ready = 1'b1;
      step(1);
      kif.key_ready = 1'b0;
      total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL b2b_level got=%0d exp=4", fifo_level); end
      total++; if (ovf_cnt - bo !== 0) begin bad++; $display("FAIL b2b_ovf got=%0d exp=0", ovf_cnt - bo); end
      swp = '0;
      step(10);
      for (int i = 0; i < 4; i++) begin
         total++; if (kif.key_code !== 5'(3 + i)) begin bad++; $display("FAIL b2b_drain%0d code=%0d exp=%0d", i, kif.key_code, 3 + i); end
         kif.key_ready = 1'b1;
         step(1);
         kif.key_ready = 1'b0;
      end
      kif.key_ready = 1'b1;
      step(2);
   endtask

   task automatic test_simultaneous;
      int b, bm;
      b = ev_cnt; bm = multi_cnt;
      swp = 12'b0110_0000_0000;
      step(12);
      total++; if (ev_cnt - b !== 1 || last_code !== 5'd2) begin bad++; $display("FAIL multi_event events=%0d code=%0d exp events=1 code=2", ev_cnt - b, last_code); end
      total++; if (multi_cnt - bm !== 1) begin bad++; $display("FAIL multi_pulse got=%0d exp=1", multi_cnt - bm); end
      swp = '0;
      step(12);
   endtask

   task automatic test_reset_hold;
      int b;
      rst = 1'b1;
      swp[3] = 1'b1;
      step(3);
      b = ev_cnt;
      rst = 1'b0;
      step(12);
      total++; if (ev_cnt - b !== 1 || last_code !== 5'd9) begin bad++; $display("FAIL reset_hold events=%0d code=%0d exp events=1 code=9", ev_cnt - b, last_code); end
      swp = '0;
      step(12);
   endtask

`ifdef KEY_REPEAT_EN
   task automatic test_repeat;
      int b;
      b = ev_cnt;
      swp[8] = 1'b1;
      step(80);
      swp = '0;
      step(20);
      total++; if (ev_cnt - b !== 5 || last_code !== 5'd4) begin bad++; $display("FAIL repeat events=%0d code=%0d exp events=5 code=4", ev_cnt - b, last_code); end
   endtask
`endif

   initial begin
      kif.key_ready = 1'b1;
      test_reset();
      test_press();
      test_bounce();
      test_function_key();
      test_fifo_full();
      test_back_to_back();
      test_simultaneous();
      test_reset_hold();
`ifdef KEY_REPEAT_EN
      test_repeat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
